gpio_apb_arb: RTL
=================

GPIO_APB_ARB -- requirements
Module: gpio_apb_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, the APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, the maximum number of ACCESS cycles allowed without pready.
REQ-004 SHALL have port pclk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-005 SHALL have port presetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have, for each requester N in {0,1}, reqN_valid (input, 1 bit): a held transaction request.
REQ-007 SHALL have reqN_write (input, 1 bit; 1=write, 0=read), reqN_addr (input, ADDR_WIDTH) and reqN_wdata (input, DATA_WIDTH).
REQ-008 SHALL have reqN_done (output, 1 bit): a one-cycle completion pulse.
REQ-009 SHALL have reqN_err (output, 1 bit): a one-cycle timeout pulse.
REQ-010 SHALL have rsp_rdata (output, DATA_WIDTH): the read data of the last completed read.
REQ-011 SHALL have APB master outputs paddr (ADDR_WIDTH), pwrite (1 bit), pselx (1 bit), penable (1 bit) and pwdata (DATA_WIDTH).
REQ-012 SHALL have APB master inputs prdata (DATA_WIDTH) and pready (1 bit), connecting to the GPIO bank slave (oe 0x00, pu 0x01, pd 0x02, a 0x03, y 0x04).

Function
REQ-013 SHALL implement a four-state FSM: IDLE, SETUP, ACCESS, RESP.
REQ-014 In IDLE with any reqN_valid high at a clock edge, SHALL latch the winner's write, addr and wdata, then enter SETUP.
REQ-015 Arbitration SHALL be round-robin: with both requests valid, the requester not most recently granted wins; with one request valid, that requester wins.
REQ-016 In SETUP, SHALL drive pselx=1 and penable=0, with paddr, pwrite and pwdata from the latched request; SETUP SHALL always last exactly 1 cycle, then enter ACCESS.
REQ-017 In ACCESS, SHALL drive pselx=1 and penable=1 with paddr, pwrite and pwdata held stable; it SHALL stay in ACCESS while pready=0.
REQ-018 On a clock edge in ACCESS with pready=1, SHALL capture prdata into rsp_rdata (reads only; writes leave rsp_rdata unchanged), update last-grant, and enter RESP.
REQ-019 In RESP, SHALL drive pselx=0 and penable=0 and assert the granted reqN_done for exactly 1 cycle; reqN_valid SHALL be ignored in RESP; RESP SHALL then return to IDLE.
REQ-020 Latency SHALL be: with a zero-wait slave, valid sampled at edge k puts pselx high after edge k, penable high after k+1, done high after k+2, and IDLE after k+3.
REQ-021 Each wait state SHALL add 1 cycle.
REQ-022 A timeout counter SHALL reset on entering ACCESS; if pready is still 0 after TIMEOUT ACCESS cycles, the block SHALL enter RESP with reqN_err pulsed instead of reqN_done, leave rsp_rdata unchanged, and update last-grant.
REQ-023 Deassertion of the granted reqN_valid after grant SHALL NOT abort the transaction: the transfer SHALL complete and done/err SHALL still pulse.
REQ-024 Changes to reqN_addr, reqN_wdata or reqN_write after grant SHALL have no effect on the APB signals.
REQ-025 Outside SETUP and ACCESS, pselx and penable SHALL be 0.
REQ-026 At most one of the four done/err outputs SHALL be high in any cycle.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 On presetn=0, SHALL immediately enter IDLE, regardless of clock.
REQ-029 On reset, pselx, penable, pwrite, all done/err outputs, paddr, pwdata and rsp_rdata SHALL be 0, and last-grant SHALL be 1 (so req0 wins the first contention).
REQ-030 Reset asserted mid-transaction SHALL drop pselx and penable asynchronously, and no done/err SHALL pulse for the aborted transfer.

Verification
REQ-031 Scenario: req0 write addr 0x00 wdata 0xA5, zero-wait slave -> SETUP/ACCESS phases exactly as REQ-020, oe=0xA5, req0_done pulses once.
REQ-032 Scenario: req1 read addr 0x04 with y=0x3C, slave inserting 3 wait states -> penable high for 4 cycles, rsp_rdata=0x3C, req1_done pulses once.
REQ-033 Scenario: both valid continuously after reset, writing 0x11 (req0) and 0x22 (req1) to addr 0x01 -> grants alternate 0,1,0,1, with the first grant to req0.
REQ-034 Scenario: pready tied 0, TIMEOUT=16 -> after 16 ACCESS cycles the requester's err pulses, done stays 0, and pselx drops.
REQ-035 Scenario: presetn pulsed low during ACCESS -> pselx=penable=0 immediately, no done/err, and the next request proceeds normally.
REQ-036 Scenario: write 0x00..0xFF then read back at each of addrs 0x00–0x03 via alternating requesters -> rsp_rdata equals the written value every time.

Source files
------------

// File: rtl/gpio_apb_arb.sv
// Two-requester round-robin arbiter driving an APB master port
// toward a GPIO register bank, with a per-transfer ACCESS timeout.
module gpio_apb_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  req0_valid,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  req0_done,
   output logic                  req0_err,
   input  logic                  req1_valid,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  req1_done,
   output logic                  req1_err,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  pwrite,
   output logic                  pselx,
   output logic                  penable,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TLAST = CW'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  gnt_q, gnt_d;
   logic                  last_q, last_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  psel_q, psel_d;
   logic                  pen_q, pen_d;
   logic [1:0]            done_q, done_d;
   logic [1:0]            err_q, err_d;
   logic [CW-1:0]         tcnt_q, tcnt_d;
   logic                  win;

   // Next-state logic: arbitration, APB phase sequencing and timeout.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      psel_d  = psel_q;
      pen_d   = pen_q;
      tcnt_d  = tcnt_q;
      done_d  = 2'b00;
      err_d   = 2'b00;
      win     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               if (req0_valid && req1_valid) win = ~last_q;
               else                          win = req1_valid;
               gnt_d   = win;
               write_d = win ? req1_write : req0_write;
               addr_d  = win ? req1_addr  : req0_addr;
               wdata_d = win ? req1_wdata : req0_wdata;
               psel_d  = 1'b1;
               pen_d   = 1'b0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            pen_d   = 1'b1;
            tcnt_d  = '0;
            state_d = S_ACCESS;
         end
         S_ACCESS: begin
            if (pready) begin
               if (!write_q) rdata_d = prdata;
               done_d[gnt_q] = 1'b1;
               last_d  = gnt_q;
               psel_d  = 1'b0;
               pen_d   = 1'b0;
               state_d = S_RESP;
            end else if (tcnt_q == TLAST) begin
               err_d[gnt_q] = 1'b1;
               last_d  = gnt_q;
               psel_d  = 1'b0;
               pen_d   = 1'b0;
               state_d = S_RESP;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            psel_d  = 1'b0;
            pen_d   = 1'b0;
         end
      endcase
   end

   // State registers; reset aborts any transfer without a completion pulse.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= S_IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         psel_q  <= 1'b0;
         pen_q   <= 1'b0;
         done_q  <= 2'b00;
         err_q   <= 2'b00;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         psel_q  <= psel_d;
         pen_q   <= pen_d;
         done_q  <= done_d;
         err_q   <= err_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign paddr     = addr_q;
   assign pwrite    = write_q;
   assign pwdata    = wdata_q;
   assign pselx     = psel_q;
   assign penable   = pen_q;
   assign rsp_rdata = rdata_q;
   assign req0_done = done_q[0];
   assign req1_done = done_q[1];
   assign req0_err  = err_q[0];
   assign req1_err  = err_q[1];

endmodule
